// File: rtl/weight_skew_ctrl.sv
// Skewed weight-feed controller: walks a step counter t across K+ROWS-1 steps,
// issuing weight-buffer reads and a diagonal per-row enable wavefront.
module weight_skew_ctrl #(
   parameter int ROWS     = 4,
   parameter int LEN_BITS = 8
) (
   input  logic                sys_clk,
   input  logic                reset,
   input  logic                start,
   input  logic [LEN_BITS-1:0] vec_len,
   input  logic                stall,
   output logic [ROWS-1:0]     row_en,
   output logic [LEN_BITS-1:0] rd_addr,
   output logic                rd_valid,
   output logic                busy,
   output logic                done
);

   localparam int ROW_BITS = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int T_BITS   = LEN_BITS + ROW_BITS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FEED = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [T_BITS-1:0]   t_q, t_d;
   logic [LEN_BITS-1:0] k_q, k_d;
   logic [ROWS-1:0]     row_en_q, row_en_d;
   logic [LEN_BITS-1:0] rd_addr_q, rd_addr_d;
   logic                rd_valid_q, rd_valid_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                issue;
   logic [T_BITS-1:0]   t_issue;
   logic [T_BITS-1:0]   k_issue;
   logic [T_BITS-1:0]   t_end;

   // Last step: the final element of K reaches the bottom row ROWS-1 steps late.
   assign t_end = T_BITS'(k_q) + T_BITS'(ROWS) - T_BITS'(2);

   always_comb begin
      state_d    = state_q;
      t_d        = t_q;
      k_d        = k_q;
      row_en_d   = '0;
      rd_addr_d  = '0;
      rd_valid_d = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      issue      = 1'b0;
      t_issue    = '0;
      k_issue    = T_BITS'(k_q);

      case (state_q)
         IDLE: begin
            if (start && (vec_len != '0)) begin
               state_d = FEED;
               k_d     = vec_len;
               t_d     = '0;
               busy_d  = 1'b1;
               issue   = 1'b1;
               t_issue = '0;
               k_issue = T_BITS'(vec_len);
            end
         end
         FEED: begin
            busy_d = 1'b1;
            if (!stall) begin
               if (t_q == t_end) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  t_d     = t_q + T_BITS'(1);
                  issue   = 1'b1;
                  t_issue = t_q + T_BITS'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are computed for the step entering the next cycle so they stay registered.
      if (issue) begin
         for (int i = 0; i < ROWS; i++) begin
            row_en_d[i] = (t_issue >= T_BITS'(i)) && (t_issue < (T_BITS'(i) + k_issue));
         end
         rd_valid_d = (t_issue < k_issue);
         rd_addr_d  = rd_valid_d ? t_issue[LEN_BITS-1:0] : '0;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state_q    <= IDLE;
         t_q        <= '0;
         k_q        <= '0;
         row_en_q   <= '0;
         rd_addr_q  <= '0;
         rd_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         t_q        <= t_d;
         k_q        <= k_d;
         row_en_q   <= row_en_d;
         rd_addr_q  <= rd_addr_d;
         rd_valid_q <= rd_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign row_en   = row_en_q;
   assign rd_addr  = rd_addr_q;
   assign rd_valid = rd_valid_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_weight_skew_ctrl.sv
// Bench for weight_skew_ctrl: directed feed scenarios plus randomized feeds
// checked against a step-level reference model.
module tb_weight_skew_ctrl;

   localparam int ROWS     = 4;
   localparam int LEN_BITS = 8;
   localparam int W        = 3 + LEN_BITS + ROWS;

   logic                sys_clk = 1'b0;
   logic                reset;
   logic                start;
   logic [LEN_BITS-1:0] vec_len;
   logic                stall;
   logic [ROWS-1:0]     row_en;
   logic [LEN_BITS-1:0] rd_addr;
   logic                rd_valid;
   logic                busy;
   logic                done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] exp_q[$];
   bit           stall_seq[$];

   always #5 sys_clk = ~sys_clk;

   weight_skew_ctrl #(.ROWS(ROWS), .LEN_BITS(LEN_BITS)) dut (
      .sys_clk  (sys_clk),
      .reset    (reset),
      .start    (start),
      .vec_len  (vec_len),
      .stall    (stall),
      .row_en   (row_en),
      .rd_addr  (rd_addr),
      .rd_valid (rd_valid),
      .busy     (busy),
      .done     (done)
   );

   // Expected output word for showing step s of a length-k feed.
   function automatic logic [W-1:0] pack_exp(input bit b, input bit d, input int s, input int k, input bit show);
      logic [ROWS-1:0]     r;
      logic                v;
      logic [LEN_BITS-1:0] a;
      r = '0;
      v = 1'b0;
      a = '0;
      if (show) begin
         for (int i = 0; i < ROWS; i++) r[i] = (i <= s) && (s < i + k);
         v = (s < k);
         a = v ? LEN_BITS'(s) : '0;
      end
      return {b, d, v, a, r};
   endfunction

   function automatic logic [W-1:0] actual();
      return {busy, done, rd_valid, rd_addr, row_en};
   endfunction

   task automatic test_reset();
      start = 1'b1; stall = 1'b1; vec_len = 8'd5; reset = 1'b1;
      @(negedge sys_clk);
      n_checks++;
      if (actual() !== '0) begin
         n_fail++; $display("FAIL reset_hold: outputs=%h expected 0", actual());
      end
      reset = 1'b0; start = 1'b1; vec_len = 8'd1; stall = 1'b0;
      @(negedge sys_clk);
      start = 1'b0;
      n_checks++;
      if (row_en !== 4'b0001 || busy !== 1'b1 || rd_valid !== 1'b1) begin
         n_fail++; $display("FAIL reset_release_start: row_en=%b busy=%b rd_valid=%b expected 0001 1 1", row_en, busy, rd_valid);
      end
      reset = 1'b1;
      @(negedge sys_clk);
      reset = 1'b0;
      n_checks++;
      if (actual() !== '0) begin
         n_fail++; $display("FAIL reset_abort: outputs=%h expected 0", actual());
      end
      @(negedge sys_clk);
      n_checks++;
      if (actual() !== '0) begin
         n_fail++; $display("FAIL reset_idle: outputs=%h expected 0", actual());
      end
   endtask

   task automatic test_vec3();
      int exp_row[6] = '{1, 3, 7, 14, 12, 8};
      int busy_cycles = 0;
      start = 1'b1; vec_len = 8'd3;
      @(negedge sys_clk);
      start = 1'b0;
      for (int n = 0; n < 6; n++) begin
         if (busy === 1'b1) busy_cycles++;
         n_checks++;
         if (row_en !== ROWS'(exp_row[n]) || rd_valid !== logic'(n < 3) ||
             rd_addr !== ((n < 3) ? LEN_BITS'(n) : '0) || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL vec3 cycle %0d: row_en=%b rd_valid=%b rd_addr=%0d busy=%b done=%b expected row_en=%b",
                     n, row_en, rd_valid, rd_addr, busy, done, ROWS'(exp_row[n]));
         end
         @(negedge sys_clk);
      end
      if (busy === 1'b1) busy_cycles++;
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b1 || row_en !== '0 || rd_valid !== 1'b0) begin
         n_fail++; $display("FAIL vec3_done: done=%b busy=%b row_en=%b rd_valid=%b expected 1 1 0000 0", done, busy, row_en, rd_valid);
      end
      @(negedge sys_clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || busy_cycles != 7) begin
         n_fail++; $display("FAIL vec3_idle: busy=%b done=%b busy_cycles=%0d expected 0 0 7", busy, done, busy_cycles);
      end
   endtask

   task automatic test_vec1();
      int exp_row[4] = '{1, 2, 4, 8};
      start = 1'b1; vec_len = 8'd1;
      @(negedge sys_clk);
      start = 1'b0;
      for (int n = 0; n < 4; n++) begin
         n_checks++;
         if (row_en !== ROWS'(exp_row[n]) || rd_valid !== logic'(n == 0) || rd_addr !== '0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL vec1 cycle %0d: row_en=%b rd_valid=%b rd_addr=%0d busy=%b expected row_en=%b",
                     n, row_en, rd_valid, rd_addr, busy, ROWS'(exp_row[n]));
         end
         @(negedge sys_clk);
      end
      n_checks++;
      if (done !== 1'b1 || row_en !== '0) begin
         n_fail++; $display("FAIL vec1_done: done=%b row_en=%b expected 1 0000", done, row_en);
      end
      @(negedge sys_clk);
   endtask

   task automatic test_ignored();
      int exp_row[6] = '{1, 3, 7, 14, 12, 8};
      start = 1'b1; vec_len = 8'd0;
      for (int n = 0; n < 3; n++) begin
         @(negedge sys_clk);
         n_checks++;
         if (actual() !== '0) begin
            n_fail++; $display("FAIL zero_len_start cycle %0d: outputs=%h expected 0", n, actual());
         end
      end
      vec_len = 8'd3;
      @(negedge sys_clk);
      vec_len = 8'd7;
      for (int n = 0; n < 6; n++) begin
         n_checks++;
         if (row_en !== ROWS'(exp_row[n]) || busy !== 1'b1) begin
            n_fail++; $display("FAIL busy_start cycle %0d: row_en=%b busy=%b expected %b 1", n, row_en, busy, ROWS'(exp_row[n]));
         end
         @(negedge sys_clk);
      end
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++; $display("FAIL busy_start_done: done=%b expected 1", done);
      end
      @(negedge sys_clk);
      start = 1'b0;
      for (int n = 0; n < 2; n++) begin
         @(negedge sys_clk);
         n_checks++;
         if (busy !== 1'b0 || row_en !== '0) begin
            n_fail++; $display("FAIL no_second_feed cycle %0d: busy=%b row_en=%b expected 0 0000", n, busy, row_en);
         end
      end
   endtask

   task automatic test_stall();
      int exp_row[8] = '{1, 3, 0, 0, 7, 14, 12, 8};
      start = 1'b1; vec_len = 8'd3;
      @(negedge sys_clk);
      start = 1'b0;
      for (int n = 0; n < 8; n++) begin
         n_checks++;
         if (row_en !== ROWS'(exp_row[n]) || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL stall cycle %0d: row_en=%b busy=%b done=%b expected %b 1 0", n, row_en, busy, done, ROWS'(exp_row[n]));
         end
         stall = (n == 1 || n == 2);
         @(negedge sys_clk);
      end
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++; $display("FAIL stall_done: done=%b expected 1", done);
      end
      stall = 1'b1;
      @(negedge sys_clk);
      stall = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++; $display("FAIL stall_in_done: busy=%b done=%b expected 0 0", busy, done);
      end
   endtask

   task automatic test_reset_mid();
      int exp_a[4] = '{1, 3, 7, 14};
      int exp_b[5] = '{1, 3, 6, 12, 8};
      start = 1'b1; vec_len = 8'd3;
      @(negedge sys_clk);
      start = 1'b0;
      for (int n = 0; n < 4; n++) begin
         n_checks++;
         if (row_en !== ROWS'(exp_a[n])) begin
            n_fail++; $display("FAIL reset_mid_pre cycle %0d: row_en=%b expected %b", n, row_en, ROWS'(exp_a[n]));
         end
         if (n < 3) @(negedge sys_clk);
      end
      reset = 1'b1;
      @(negedge sys_clk);
      n_checks++;
      if (actual() !== '0) begin
         n_fail++; $display("FAIL reset_mid_abort: outputs=%h expected 0", actual());
      end
      reset = 1'b0; start = 1'b1; vec_len = 8'd2;
      @(negedge sys_clk);
      start = 1'b0;
      for (int n = 0; n < 5; n++) begin
         n_checks++;
         if (row_en !== ROWS'(exp_b[n]) || done !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_k2 cycle %0d: row_en=%b done=%b expected %b 0", n, row_en, done, ROWS'(exp_b[n]));
         end
         @(negedge sys_clk);
      end
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++; $display("FAIL reset_mid_k2_done: done=%b expected 1", done);
      end
      @(negedge sys_clk);
   endtask

   task automatic test_back_to_back();
      int exp_row[7]  = '{1, 2, 4, 8, 0, 0, 1};
      int exp_busy[7] = '{1, 1, 1, 1, 1, 0, 1};
      int exp_done[7] = '{0, 0, 0, 0, 1, 0, 0};
      start = 1'b1; vec_len = 8'd1;
      @(negedge sys_clk);
      for (int n = 0; n < 7; n++) begin
         n_checks++;
         if (row_en !== ROWS'(exp_row[n]) || busy !== logic'(exp_busy[n]) || done !== logic'(exp_done[n])) begin
            n_fail++;
            $display("FAIL back_to_back cycle %0d: row_en=%b busy=%b done=%b expected %b %0d %0d",
                     n, row_en, busy, done, ROWS'(exp_row[n]), exp_busy[n], exp_done[n]);
         end
         if (n < 6) @(negedge sys_clk);
      end
      start = 1'b0; reset = 1'b1;
      @(negedge sys_clk);
      reset = 1'b0;
   endtask

   // Reference: step index advances once per unstalled cycle; a stalled cycle shows zeros.
   task automatic run_model(input int k, input int pct, input bit poke);
      int           shown = 0;
      int           phase = 0;
      bit           zero  = 1'b0;
      int           guard = 0;
      int           t_end = k + ROWS - 2;
      bit           s;
      logic [W-1:0] e;
      exp_q.delete();
      stall_seq.delete();
      while (phase != 2 && guard < 4000) begin
         guard++;
         if (phase == 0) exp_q.push_back(pack_exp(1'b1, 1'b0, shown, k, !zero));
         else            exp_q.push_back(pack_exp(1'b1, 1'b1, 0, k, 1'b0));
         s = ($urandom_range(99) < pct);
         stall_seq.push_back(s);
         if (phase == 1)           phase = 2;
         else if (s)               zero = 1'b1;
         else if (shown == t_end)  phase = 1;
         else begin shown++; zero = 1'b0; end
      end
      exp_q.push_back('0);
      stall_seq.push_back(1'b0);
      start = 1'b1; vec_len = LEN_BITS'(k);
      @(negedge sys_clk);
      start = 1'b0;
      for (int n = 0; exp_q.size() > 0; n++) begin
         e = exp_q.pop_front();
         n_checks++;
         if (actual() !== e) begin
            n_fail++; $display("FAIL model k=%0d cycle %0d: got %h expected %h", k, n, actual(), e);
         end
         stall = stall_seq[n];
         if (poke && exp_q.size() > 0) begin
            start   = ($urandom_range(3) == 0);
            vec_len = LEN_BITS'($urandom_range(255));
         end else begin
            start = 1'b0;
         end
         @(negedge sys_clk);
      end
      stall = 1'b0;
      start = 1'b0;
   endtask

   task automatic test_long();
      run_model(255, 0, 1'b0);
   endtask

   task automatic test_random();
      for (int f = 0; f < 12; f++) begin
         run_model(($urandom_range(9) == 0) ? $urandom_range(255, 1) : $urandom_range(12, 1), 30, 1'b1);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stall = 1'b0; vec_len = '0;
      repeat (2) @(negedge sys_clk);
      test_reset();
      test_vec3();
      test_vec1();
      test_ignored();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      test_long();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/weight_skew_ctrl.md
WEIGHT_SKEW_CTRL -- requirements
Module: weight_skew_ctrl

Interface
REQ-001 Parameter ROWS, default 4: number of PE rows fed; one zero-gating selector per row.
REQ-002 Parameter LEN_BITS, default 8: width of the vector-length field and the read address.
REQ-003 sys_clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 start  input  1  request to feed one weight vector; sampled every cycle.
REQ-006 vec_len  input  LEN_BITS  elements per row (K); sampled only when start is accepted.
REQ-007 stall  input  1  freezes feed progress while high.
REQ-008 row_en  output  ROWS  per-row enable to the selectors; bit i drives row i.
REQ-009 rd_addr  output  LEN_BITS  weight-buffer read address.
REQ-010 rd_valid  output  1  rd_addr is valid this cycle.
REQ-011 busy  output  1  high from acceptance until done completes.
REQ-012 done  output  1  one-cycle pulse when a feed completes.

Function
REQ-013 FSM states are IDLE, FEED and DONE; the block SHALL leave reset in IDLE.
REQ-014 In IDLE, start=1 with vec_len!=0 is accepted at that edge: K latches, the step counter t is cleared to 0, and the state goes to FEED.
REQ-015 In IDLE, start with vec_len=0 is ignored: the block stays in IDLE and no outputs toggle.
REQ-016 start while busy=1 is ignored, and the latched K is not modified.
REQ-017 t SHALL be LEN_BITS+clog2(ROWS) bits wide so that it never wraps; last step T_end = K+ROWS-2.
REQ-018 In FEED, when stall=0, registered outputs reflect t:
- row_en[i] = 1 iff i <= t < i+K;
- rd_valid = 1 iff t < K;
- rd_addr = t[LEN_BITS-1:0] when rd_valid, else 0.
REQ-019 In FEED, when stall=1:
- t holds;
- row_en = 0, rd_valid = 0, rd_addr = 0;
- outputs resume with the held t in the first cycle after stall drops.
REQ-020 t increments by 1 per non-stalled FEED cycle; in the non-stalled cycle with t = T_end, the next state is DONE.
REQ-021 DONE lasts exactly one cycle:
- done = 1, busy = 1, row_en = 0, rd_valid = 0;
- next state is IDLE; stall is ignored.
REQ-022 start is accepted again on the first IDLE cycle after DONE, giving back-to-back feeds with one idle gap.
REQ-023 Outputs are driven from registers only; there is no combinational path from any input to any output.
REQ-024 Downstream selectors add one cycle of enable delay; the weight buffer has one-cycle read latency, so rd_addr and row_en are issued in the same cycle.
REQ-025 busy = 1 in FEED and DONE, and 0 in IDLE.

Reset
REQ-026 While reset = 1 at an edge, all of the following take effect at that edge, overriding start and stall:
- state = IDLE, t = 0, K = 0;
- row_en = 0, rd_addr = 0, rd_valid = 0, busy = 0, done = 0.
REQ-027 Reset asserted mid-FEED aborts the feed: no done pulse, and outputs are 0 in the cycle after the reset edge.
REQ-028 After reset deasserts, a start is accepted on the first following edge.

Verification (ROWS=4)
REQ-029 vec_len=3, start, no stall:
- row_en over the six FEED cycles = 0001, 0011, 0111, 1110, 1100, 1000;
- rd_addr = 0, 1, 2 with rd_valid high for the first three cycles only;
- done pulses in the 7th cycle after acceptance; busy high for 7 cycles.
REQ-030 vec_len=1 -> row_en walks 0001, 0010, 0100, 1000; rd_valid is high in the first cycle only; then done.
REQ-031 Ignored starts:
- start pulsed during FEED -> no effect and no second feed;
- start with vec_len=0 in IDLE -> busy stays 0.
REQ-032 vec_len=3, stall high for 2 cycles at t=2:
- row_en = 0000 during the stall, then 0111, 1110, 1100, 1000;
- done arrives 2 cycles later than in REQ-029.
REQ-033 Reset at t=3 of a vec_len=3 feed -> all outputs 0 next cycle and no done; a new start with vec_len=2 then yields 0001, 0011, 0110, 1100, 1000.
REQ-034 vec_len=255 -> 258 FEED cycles; t reaches 257 without wrap; rd_addr runs 0..254; done follows the last cycle.
